// File: rtl/regfile_wb.sv
// Write-back stage: one-entry result holding register in front of the general register file
// and PSW, with commit bypass on both read ports and a running commit counter.
module regfile_wb #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       rd_a_idx,
    input  logic [2:0]       rd_b_idx,
    output logic [15:0]      rd_a_data,
    output logic [15:0]      rd_b_data,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [2:0]       wb_dst,
    input  logic [15:0]      wb_result,
    input  logic             wb_byte,
    input  logic             wb_reg_en,
    input  logic             wb_psw_en,
    input  logic [15:0]      wb_psw,
    input  logic             psw_ld,
    input  logic [15:0]      psw_ld_data,
    output logic [15:0]      psw_q,
    output logic [CNT_W-1:0] commit_cnt
);

    typedef enum logic [1:0] {StEmpty, StFull, StStall} state_e;

    state_e state_q, state_d;

    logic [15:0]      regs_q [NREG];
    logic [15:0]      psw_reg_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]  h_dst_q;
    logic [15:0] h_result_q;
    logic        h_byte_q;
    logic        h_reg_en_q;
    logic        h_psw_en_q;
    logic [15:0] h_psw_q;

    logic        held;
    logic        commit;
    logic        accept;
    logic        reg_wr;
    logic [15:0] commit_val;

    // A held entry that updates the PSW must wait while a direct PSW load is requested.
    assign held   = (state_q != StEmpty);
    assign commit = held && !(psw_ld && h_psw_en_q);
    assign accept = wb_valid && wb_ready;
    assign reg_wr = commit && h_reg_en_q;

    assign commit_val = h_byte_q ? {regs_q[h_dst_q][15:8], h_result_q[7:0]} : h_result_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) state_d = StFull;
            end
            StFull: begin
                if (!commit)     state_d = StStall;
                else if (accept) state_d = StFull;
                else             state_d = StEmpty;
            end
            StStall: begin
                if (commit) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    // Output logic
    always_comb begin
        wb_ready = 1'b0;
        unique case (state_q)
            StEmpty: wb_ready = 1'b1;
            StFull:  wb_ready = commit;
            StStall: wb_ready = 1'b0;
            default: wb_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_dst_q    <= 3'd0;
            h_result_q <= 16'h0000;
            h_byte_q   <= 1'b0;
            h_reg_en_q <= 1'b0;
            h_psw_en_q <= 1'b0;
            h_psw_q    <= 16'h0000;
        end else if (accept) begin
            h_dst_q    <= wb_dst;
            h_result_q <= wb_result;
            h_byte_q   <= wb_byte;
            h_reg_en_q <= wb_reg_en;
            h_psw_en_q <= wb_psw_en;
            h_psw_q    <= wb_psw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (reg_wr) begin
            regs_q[h_dst_q] <= commit_val;
        end
    end

    // A committing ALU PSW only occurs with psw_ld low, so the two writes never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_reg_q <= 16'h0000;
        end else if (commit && h_psw_en_q) begin
            psw_reg_q <= h_psw_q;
        end else if (psw_ld) begin
            psw_reg_q <= psw_ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (commit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd_a_data = regs_q[rd_a_idx];
        rd_b_data = regs_q[rd_b_idx];
        if (reg_wr && (rd_a_idx == h_dst_q)) rd_a_data = commit_val;
        if (reg_wr && (rd_b_idx == h_dst_q)) rd_b_data = commit_val;
    end

    assign psw_q      = psw_reg_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: each accepted result queues its expected post-commit
// register, PSW and count; a monitor pops and compares whenever commit_cnt advances.
module tb_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rd_a_idx;
    logic [2:0]  rd_b_idx;
    logic [15:0] rd_a_data;
    logic [15:0] rd_b_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_dst;
    logic [15:0] wb_result;
    logic        wb_byte;
    logic        wb_reg_en;
    logic        wb_psw_en;
    logic [15:0] wb_psw;
    logic        psw_ld;
    logic [15:0] psw_ld_data;
    logic [15:0] psw_q;
    logic [15:0] commit_cnt;

    regfile_wb #(
        .NREG  (8),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_a_idx    (rd_a_idx),
        .rd_b_idx    (rd_b_idx),
        .rd_a_data   (rd_a_data),
        .rd_b_data   (rd_b_data),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_dst      (wb_dst),
        .wb_result   (wb_result),
        .wb_byte     (wb_byte),
        .wb_reg_en   (wb_reg_en),
        .wb_psw_en   (wb_psw_en),
        .wb_psw      (wb_psw),
        .psw_ld      (psw_ld),
        .psw_ld_data (psw_ld_data),
        .psw_q       (psw_q),
        .commit_cnt  (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] reg_val;
        logic [15:0] psw_val;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_regs [8];
    logic [15:0] m_psw;
    logic [15:0] m_cnt;
    logic [15:0] prev_cnt;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_psw = 16'h0000;
        m_cnt = 16'h0000;
        sb.delete();
    endtask

    // Presents one result at a negedge, holds it through the accepting edge and queues the
    // expected outcome. waits reports how many cycles ready was low.
    task automatic push(input logic [2:0] dst, input logic [15:0] res, input logic byt,
                        input logic reg_en, input logic psw_en, input logic [15:0] psw,
                        output int waits);
        exp_t e;
        @(negedge clk);
        wb_valid  = 1'b1;
        wb_dst    = dst;
        wb_result = res;
        wb_byte   = byt;
        wb_reg_en = reg_en;
        wb_psw_en = psw_en;
        wb_psw    = psw;
        #1;
        waits = 0;
        while (!wb_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!wb_ready) check("ready timeout", 32'(wb_ready), 32'd1);
        @(posedge clk);
        if (reg_en) m_regs[dst] = byt ? {m_regs[dst][15:8], res[7:0]} : res;
        if (psw_en) m_psw = psw;
        m_cnt++;
        e.dst     = dst;
        e.reg_val = m_regs[dst];
        e.psw_val = m_psw;
        e.cnt     = m_cnt;
        sb.push_back(e);
    endtask

    // Monitor: each advance of commit_cnt retires the oldest expected entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && commit_cnt != prev_cnt) begin
            if (sb.size() == 0) begin
                check("spurious commit", 32'(commit_cnt), 32'(prev_cnt));
            end else begin
                e = sb.pop_front();
                rd_b_idx = e.dst;
                #1;
                check("commit cnt", 32'(commit_cnt), 32'(e.cnt));
                check("commit psw", 32'(psw_q), 32'(e.psw_val));
                check("commit reg", 32'(rd_b_data), 32'(e.reg_val));
            end
        end
        prev_cnt = commit_cnt;
    end

    initial begin
        int w;
        n_cmp = 0;
        n_err = 0;
        prev_cnt = 16'h0000;
        rst_n = 1'b0;
        rd_a_idx = 3'd0;
        rd_b_idx = 3'd0;
        wb_valid = 1'b0;
        wb_dst = 3'd0;
        wb_result = 16'h0000;
        wb_byte = 1'b0;
        wb_reg_en = 1'b0;
        wb_psw_en = 1'b0;
        wb_psw = 16'h0000;
        psw_ld = 1'b0;
        psw_ld_data = 16'h0000;
        model_reset();

        // Reset state
        #12;
        check("reset ready", 32'(wb_ready), 32'd1);
        check("reset psw", 32'(psw_q), 32'h0);
        check("reset cnt", 32'(commit_cnt), 32'h0);
        for (int i = 0; i < 8; i += 3) begin
            rd_a_idx = 3'(i);
            #1;
            check("reset reg", 32'(rd_a_data), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Word write with PSW
        push(3'd3, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0004, w);
        @(negedge clk);
        wb_valid = 1'b0;
        rd_a_idx = 3'd3;
        #1;
        check("word R3 bypass", 32'(rd_a_data), 32'h1234);

        // Byte write keeps the high byte
        push(3'd3, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h0000, w);

        // Bypass of an in-flight commit
        push(3'd2, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0000, w);
        @(negedge clk);
        wb_valid = 1'b0;
        rd_a_idx = 3'd2;
        #1;
        check("bypass R2", 32'(rd_a_data), 32'h5555);
        rd_a_idx = 3'd3;
        #1;
        check("byte R3", 32'(rd_a_data), 32'h12CD);

        // PSW load conflict stalls the held PSW commit
        push(3'd5, 16'h00FF, 1'b0, 1'b1, 1'b1, 16'h000A, w);
        @(negedge clk);
        wb_valid = 1'b0;
        psw_ld = 1'b1;
        psw_ld_data = 16'h0011;
        rd_a_idx = 3'd5;
        #1;
        check("conflict ready", 32'(wb_ready), 32'd0);
        check("conflict no bypass", 32'(rd_a_data), 32'h0000);
        @(negedge clk);
        #1;
        check("stall psw_ld", 32'(psw_q), 32'h0011);
        check("stall ready", 32'(wb_ready), 32'd0);
        check("stall cnt", 32'(commit_cnt), 32'd3);
        psw_ld = 1'b0;
        #1;
        check("stall release ready", 32'(wb_ready), 32'd0);
        check("stall release bypass", 32'(rd_a_data), 32'h00FF);
        @(negedge clk);
        check("after stall psw", 32'(psw_q), 32'h000A);

        // Back-to-back stream; the last is a compare form with no register write
        push(3'd0, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h0001, w);
        check("b2b ready 0", 32'(w), 32'd0);
        push(3'd1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0000, w);
        check("b2b ready 1", 32'(w), 32'd0);
        push(3'd4, 16'h4444, 1'b1, 1'b1, 1'b1, 16'h0002, w);
        check("b2b ready 2", 32'(w), 32'd0);
        push(3'd1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0008, w);
        check("b2b ready 3", 32'(w), 32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        check("b2b cnt", 32'(commit_cnt), 32'(m_cnt));
        rd_a_idx = 3'd1;
        #1;
        check("cmp keeps R1", 32'(rd_a_data), 32'h2222);

        // Direct PSW load while empty
        psw_ld = 1'b1;
        psw_ld_data = 16'h00F0;
        @(negedge clk);
        psw_ld = 1'b0;
        m_psw = 16'h00F0;
        check("psw_ld empty", 32'(psw_q), 32'h00F0);

        // Reset while stalled discards the held entry
        push(3'd7, 16'h7777, 1'b0, 1'b1, 1'b1, 16'h0003, w);
        @(negedge clk);
        wb_valid = 1'b0;
        psw_ld = 1'b1;
        psw_ld_data = 16'h0020;
        @(negedge clk);
        #1;
        check("pre-reset stall ready", 32'(wb_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async reset cnt", 32'(commit_cnt), 32'h0);
        check("async reset psw", 32'(psw_q), 32'h0);
        check("async reset ready", 32'(wb_ready), 32'd1);
        rd_a_idx = 3'd3;
        #1;
        check("async reset R3", 32'(rd_a_data), 32'h0);
        model_reset();
        psw_ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd_a_idx = 3'd7;
        #1;
        check("no commit after reset", 32'(commit_cnt), 32'h0);
        check("R7 discarded", 32'(rd_a_data), 32'h0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
